// File: rtl/reqrsp_pkg.sv
// Request/response protocol definitions shared across the cluster.
// Holds the RISC-V atomic memory operation encoding carried on the
// request channel of every TCDM port.
package reqrsp_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

endpackage

// File: rtl/snitch_tcdm_pkg.sv
// Shared definitions for the TCDM bank endpoint: atomic lane width,
// response-pipe entry, responder FSM states and the default bank
// request/response channel types.
package snitch_tcdm_pkg;

  import reqrsp_pkg::*;

  localparam int unsigned AmoLaneWidth  = 32;
  localparam int unsigned TcdmAddrWidth = 32;
  localparam int unsigned TcdmDataWidth = 64;
  localparam int unsigned TcdmStrbWidth = TcdmDataWidth / 8;

  // One entry of the response latency pipe, captured at the q handshake.
  typedef struct packed {
    logic valid;
    logic is_write;
  } rsp_pipe_t;

  // Responder FSM: IDLE accepts requests, AMO_WB is the single
  // write-back cycle of a read-modify-write atomic.
  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WB = 1'b1
  } state_e;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0] addr;
    logic                     write;
    amo_op_e                  amo;
    logic [TcdmDataWidth-1:0] data;
    logic [TcdmStrbWidth-1:0] strb;
    logic                     user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

  // True for the atomics executed locally as read-modify-write. LR, SC
  // and unknown encodings are served as plain reads.
  function automatic logic amo_is_rmw(amo_op_e op);
    logic rmw;
    case (op)
      AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
      AMOMax, AMOMaxu, AMOMin, AMOMinu: rmw = 1'b1;
      default:                          rmw = 1'b0;
    endcase
    return rmw;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Fixed-depth delay line with synchronous clear.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high clear of every stage
//   d_i    value entering the line
//   d_o    value leaving the line, Depth cycles later
// Depth must be at least 1.
module shift_reg #(
  parameter type         dtype = logic,
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  dtype d_i,
  output dtype d_o
);

  dtype regs_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        regs_q[i] <= regs_q[i-1];
      end
    end
  end

  assign d_o = regs_q[Depth-1];

endmodule

// File: rtl/snitch_amo_alu.sv
// Combinational atomic-operation datapath for one 32-bit lane.
// Ports:
//   op       atomic operation
//   old      current memory lane value
//   operand  lane value carried by the request
//   result   value to write back; equals old for non-modifying ops
module snitch_amo_alu
  import reqrsp_pkg::*;
  import snitch_tcdm_pkg::*;
(
  input  amo_op_e                 op,
  input  logic [AmoLaneWidth-1:0] old,
  input  logic [AmoLaneWidth-1:0] operand,
  output logic [AmoLaneWidth-1:0] result
);

  always_comb begin
    result = old;
    case (op)
      AMOSwap: result = operand;
      AMOAdd:  result = old + operand;
      AMOAnd:  result = old & operand;
      AMOOr:   result = old | operand;
      AMOXor:  result = old ^ operand;
      AMOMax:  result = ($signed(old) > $signed(operand)) ? old : operand;
      AMOMaxu: result = (old > operand) ? old : operand;
      AMOMin:  result = ($signed(old) < $signed(operand)) ? old : operand;
      AMOMinu: result = (old < operand) ? old : operand;
      default: result = old;
    endcase
  end

endmodule

// File: rtl/snitch_tcdm_bank_responder.sv
// Memory-side endpoint of one TCDM bank port. Drives a single-port SRAM,
// returns read data a fixed MemoryResponseLatency cycles after the q
// handshake and executes atomics as a read followed by one write-back cycle.
//
// Handshake: a request transfers in a cycle where q_valid and q_ready are
// both high. q_ready depends only on reset and FSM state, never on q_valid.
// The p channel has no ready: a response is presented for exactly one
// cycle (marked by p_valid_o) and must be consumed by the router.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   mem_req_i     {q_valid, q{addr, write, amo, data, strb, user}}
//   mem_rsp_o     {q_ready, p{data}}
//   p_valid_o     high in the cycle p.data carries a response
//   sram_req_o    SRAM access enable
//   sram_we_o     SRAM write enable
//   sram_addr_o   SRAM word address
//   sram_wdata_o  SRAM write data
//   sram_be_o     SRAM byte enables
//   sram_rdata_i  SRAM read data, valid one cycle after a read access
module snitch_tcdm_bank_responder
  import reqrsp_pkg::*;
  import snitch_tcdm_pkg::*;
#(
  parameter int unsigned NumWords              = 1024,
  parameter int unsigned DataWidth             = 64,
  parameter int unsigned MemoryResponseLatency = 1,
  parameter type         user_t                = logic,
  parameter type         mem_req_t             = tcdm_req_t,
  parameter type         mem_rsp_t             = tcdm_rsp_t,
  localparam int unsigned AddrWidth            = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  mem_req_t               mem_req_i,
  output mem_rsp_t               mem_rsp_o,
  output logic                   p_valid_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned NumLanes  = DataWidth / AmoLaneWidth;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ReqAddrW  = $bits(mem_req_i.q.addr);

  // The user payload and the address bits above the bank depth carry no
  // meaning at this endpoint.
  user_t                            unused_user;
  logic [ReqAddrW-AddrWidth-1:0]    unused_addr;
  assign unused_user = mem_req_i.q.user;
  assign unused_addr = mem_req_i.q.addr[ReqAddrW-1:AddrWidth];

  // --------------------------------------------------------------------
  // Handshake and request decode
  // --------------------------------------------------------------------
  state_e state_q, state_d;

  logic q_ready;
  logic accept;
  logic is_plain;
  logic is_rmw;
  logic plain_write;

  assign q_ready     = !rst_i && (state_q == IDLE);
  assign accept      = mem_req_i.q_valid && q_ready;
  assign is_plain    = (mem_req_i.q.amo == AMONone);
  assign is_rmw      = amo_is_rmw(mem_req_i.q.amo);
  // Atomics never write in the accept cycle, whatever the write bit says.
  assign plain_write = mem_req_i.q.write && is_plain;

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_rmw) state_d = AMO_WB;
      AMO_WB:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Atomic context, held for the write-back cycle.
  logic [AddrWidth-1:0] amo_addr_q;
  logic [DataWidth-1:0] amo_operand_q;
  logic [StrbWidth-1:0] amo_strb_q;
  amo_op_e              amo_op_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      amo_addr_q    <= '0;
      amo_operand_q <= '0;
      amo_strb_q    <= '0;
      amo_op_q      <= AMONone;
    end else if (accept && is_rmw) begin
      amo_addr_q    <= mem_req_i.q.addr[AddrWidth-1:0];
      amo_operand_q <= mem_req_i.q.data;
      amo_strb_q    <= mem_req_i.q.strb;
      amo_op_q      <= mem_req_i.q.amo;
    end
  end

  // --------------------------------------------------------------------
  // Atomic datapath. During AMO_WB the SRAM output still holds the word
  // read in the accept cycle, so it is the old value directly. A lane is
  // modified only when all four of its strobes are set.
  // --------------------------------------------------------------------
  logic [DataWidth-1:0] amo_wdata;
  logic [StrbWidth-1:0] amo_be;

  for (genvar l = 0; l < NumLanes; l++) begin : gen_lane
    logic [AmoLaneWidth-1:0] lane_new;
    logic                    lane_en;

    snitch_amo_alu i_amo_alu (
      .op      (amo_op_q),
      .old     (sram_rdata_i[l*AmoLaneWidth +: AmoLaneWidth]),
      .operand (amo_operand_q[l*AmoLaneWidth +: AmoLaneWidth]),
      .result  (lane_new)
    );

    assign lane_en = &amo_strb_q[l*4 +: 4];
    assign amo_wdata[l*AmoLaneWidth +: AmoLaneWidth] =
        lane_en ? lane_new : sram_rdata_i[l*AmoLaneWidth +: AmoLaneWidth];
    assign amo_be[l*4 +: 4] = {4{lane_en}};
  end

  // --------------------------------------------------------------------
  // SRAM port. Reset wins over a pending write-back.
  // --------------------------------------------------------------------
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (!rst_i) begin
      if (state_q == AMO_WB) begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = amo_addr_q;
        sram_wdata_o = amo_wdata;
        sram_be_o    = amo_be;
      end else if (accept) begin
        sram_req_o   = 1'b1;
        sram_we_o    = plain_write;
        sram_addr_o  = mem_req_i.q.addr[AddrWidth-1:0];
        sram_wdata_o = mem_req_i.q.data;
        sram_be_o    = plain_write ? mem_req_i.q.strb : '1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Response pipe. Stage 0 lines up with the SRAM read latency; the
  // remaining MemoryResponseLatency-1 stages carry {valid, data}.
  // --------------------------------------------------------------------
  rsp_pipe_t            stage_in;
  rsp_pipe_t            stage_out;
  logic [DataWidth:0]   rsp_head;
  logic [DataWidth:0]   rsp_tail;

  assign stage_in.valid    = accept;
  assign stage_in.is_write = accept && plain_write;

  shift_reg #(
    .dtype (rsp_pipe_t),
    .Depth (1)
  ) i_stage0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (stage_in),
    .d_o   (stage_out)
  );

  assign rsp_head = {stage_out.valid,
                     (stage_out.valid && !stage_out.is_write) ? sram_rdata_i : '0};

  if (MemoryResponseLatency > 1) begin : gen_delay
    shift_reg #(
      .dtype (logic [DataWidth:0]),
      .Depth (MemoryResponseLatency - 1)
    ) i_delay (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (rsp_head),
      .d_o   (rsp_tail)
    );
  end else begin : gen_no_delay
    assign rsp_tail = rsp_head;
  end

  assign p_valid_o = !rst_i && rsp_tail[DataWidth];

  always_comb begin
    mem_rsp_o         = '0;
    mem_rsp_o.q_ready = q_ready;
    if (!rst_i) begin
      mem_rsp_o.p.data = rsp_tail[DataWidth-1:0];
    end
  end

endmodule

// File: tb/tb_snitch_tcdm_bank_responder.sv
// Bench for snitch_tcdm_bank_responder: two instances (latency 1 and 3)
// share one request stream, each with its own SRAM model. A directed
// vector table checks the latency-1 instance cycle by cycle; a reference
// memory model checks both instances on every cycle.
module tb_snitch_tcdm_bank_responder;
  import reqrsp_pkg::*;
  import snitch_tcdm_pkg::*;

  localparam int NumWords = 1024;
  localparam int AW       = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  tcdm_req_t req;
  tcdm_rsp_t rsp1, rsp3;
  logic          pv1, pv3, sreq1, sreq3, swe1, swe3;
  logic [AW-1:0] saddr1, saddr3;
  logic [63:0]   swd1, swd3, srd1, srd3;
  logic [7:0]    sbe1, sbe3;
  logic [63:0]   sram1 [NumWords];
  logic [63:0]   sram3 [NumWords];

  snitch_tcdm_bank_responder #(.NumWords(NumWords), .DataWidth(64), .MemoryResponseLatency(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req), .mem_rsp_o(rsp1), .p_valid_o(pv1),
    .sram_req_o(sreq1), .sram_we_o(swe1), .sram_addr_o(saddr1), .sram_wdata_o(swd1),
    .sram_be_o(sbe1), .sram_rdata_i(srd1));

  snitch_tcdm_bank_responder #(.NumWords(NumWords), .DataWidth(64), .MemoryResponseLatency(3)) dut_l3 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req), .mem_rsp_o(rsp3), .p_valid_o(pv3),
    .sram_req_o(sreq3), .sram_we_o(swe3), .sram_addr_o(saddr3), .sram_wdata_o(swd3),
    .sram_be_o(sbe3), .sram_rdata_i(srd3));

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NumWords; i++) sram1[i] <= '0;
    end else if (sreq1) begin
      if (swe1) begin
        for (int b = 0; b < 8; b++) if (sbe1[b]) sram1[saddr1][8*b +: 8] <= swd1[8*b +: 8];
      end else begin
        srd1 <= sram1[saddr1];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NumWords; i++) sram3[i] <= '0;
    end else if (sreq3) begin
      if (swe3) begin
        for (int b = 0; b < 8; b++) if (sbe3[b]) sram3[saddr3][8*b +: 8] <= swd3[8*b +: 8];
      end else begin
        srd3 <= sram3[saddr3];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic [63:0] ref_mem [NumWords];
  exp_t        exp_q1[$];
  exp_t        exp_q3[$];
  bit          wb_pending = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [63:0] wb_opnd;
  logic [7:0]  wb_strb;
  amo_op_e     wb_op;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Directed-table expectations for the latency-1 instance.
  bit          tbl_on = 1'b0;
  logic        tbl_ready, tbl_pv;
  logic [63:0] tbl_pd;

  function automatic logic [31:0] lane_op(amo_op_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    case (op)
      AMOSwap: return b;
      AMOAdd:  return 32'((ua + ub) % 64'h1_0000_0000);
      AMOAnd:  return a & b;
      AMOOr:   return a | b;
      AMOXor:  return a ^ b;
      AMOMax:  return (sa >= sb) ? a : b;
      AMOMin:  return (sa <= sb) ? a : b;
      AMOMaxu: return (ua >= ub) ? a : b;
      AMOMinu: return (ua <= ub) ? a : b;
      default: return a;
    endcase
  endfunction

  function automatic logic [63:0] amo_word(amo_op_e op, logic [63:0] old, logic [63:0] opnd, logic [7:0] strb);
    logic [63:0] res;
    res = old;
    for (int l = 0; l < 2; l++)
      if (strb[4*l +: 4] == 4'hF) res[32*l +: 32] = lane_op(op, old[32*l +: 32], opnd[32*l +: 32]);
    return res;
  endfunction

  function automatic logic [63:0] strb_mask(logic [7:0] strb);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic bit is_rmw(amo_op_e op);
    return op inside {AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor, AMOMax, AMOMaxu, AMOMin, AMOMinu};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic qr, input logic sr, input logic we,
                            input logic [AW-1:0] ad, input logic [63:0] wd, input logic [7:0] be,
                            input logic pv, input logic [63:0] pd,
                            input bit e_ready, input bit e_req, input bit e_we,
                            input logic [AW-1:0] e_addr, input logic [63:0] e_wd, input logic [7:0] e_be,
                            input bit e_wd_chk, input bit have, input logic [63:0] e_pd);
    check({"q_ready_", tag}, qr, e_ready);
    check({"sram_req_", tag}, sr, e_req);
    check({"sram_we_", tag}, we, e_we);
    if (e_req) begin
      check({"sram_addr_", tag}, ad, e_addr);
      check({"sram_be_", tag}, be, e_be);
    end
    if (e_wd_chk) check({"sram_wdata_", tag}, wd & strb_mask(e_be), e_wd & strb_mask(e_be));
    check({"p_valid_", tag}, pv, have);
    check({"p_data_", tag}, pd, have ? e_pd : 64'h0);
  endtask

  // One clock cycle: compare at the falling edge, advance the model at
  // the rising edge, release the driver just after it.
  task automatic tick();
    bit e_ready, accept, e_req, e_we, e_wd_chk, h1, h3;
    logic [AW-1:0] a, e_addr;
    logic [63:0] d1, d3, e_wd, old, rdat;
    logic [7:0] e_be;
    @(negedge clk);
    a        = req.q.addr[AW-1:0];
    e_ready  = !rst && !wb_pending;
    accept   = req.q_valid && e_ready;
    e_req    = !rst && (wb_pending || accept);
    e_we     = !rst && (wb_pending || (accept && req.q.write && req.q.amo == AMONone));
    e_addr   = wb_pending ? wb_addr : a;
    e_wd_chk = e_we;
    if (wb_pending) begin
      e_be = {{4{&wb_strb[7:4]}}, {4{&wb_strb[3:0]}}};
      e_wd = amo_word(wb_op, ref_mem[wb_addr], wb_opnd, wb_strb);
    end else begin
      e_be = e_we ? req.q.strb : 8'hFF;
      e_wd = req.q.data;
    end
    h1 = !rst && exp_q1.size() != 0 && exp_q1[0].due == cyc;
    h3 = !rst && exp_q3.size() != 0 && exp_q3[0].due == cyc;
    d1 = h1 ? exp_q1[0].data : 64'h0;
    d3 = h3 ? exp_q3[0].data : 64'h0;
    check_port("l1", rsp1.q_ready, sreq1, swe1, saddr1, swd1, sbe1, pv1, rsp1.p.data,
               e_ready, e_req, e_we, e_addr, e_wd, e_be, e_wd_chk, h1, d1);
    check_port("l3", rsp3.q_ready, sreq3, swe3, saddr3, swd3, sbe3, pv3, rsp3.p.data,
               e_ready, e_req, e_we, e_addr, e_wd, e_be, e_wd_chk, h3, d3);
    if (h1) void'(exp_q1.pop_front());
    if (h3) void'(exp_q3.pop_front());
    if (tbl_on) begin
      check("tbl_q_ready", rsp1.q_ready, tbl_ready);
      check("tbl_p_valid", pv1, tbl_pv);
      check("tbl_p_data", rsp1.p.data, tbl_pd);
    end
    @(posedge clk);
    if (rst) begin
      exp_q1.delete();
      exp_q3.delete();
      wb_pending = 1'b0;
    end else begin
      if (wb_pending) begin
        ref_mem[wb_addr] = amo_word(wb_op, ref_mem[wb_addr], wb_opnd, wb_strb);
        wb_pending = 1'b0;
      end
      if (accept) begin
        old = ref_mem[a];
        if (req.q.amo == AMONone && req.q.write) begin
          ref_mem[a] = (old & ~strb_mask(req.q.strb)) | (req.q.data & strb_mask(req.q.strb));
          rdat = 64'h0;
        end else begin
          rdat = old;
        end
        exp_q1.push_back('{due: cyc + 1, data: rdat});
        exp_q3.push_back('{due: cyc + 3, data: rdat});
        if (is_rmw(req.q.amo)) begin
          wb_pending = 1'b1;
          wb_addr    = a;
          wb_opnd    = req.q.data;
          wb_strb    = req.q.strb;
          wb_op      = req.q.amo;
        end
      end
    end
    cyc++;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        valid;
    logic        write;
    amo_op_e     amo;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        exp_ready;
    logic        exp_pv;
    logic [63:0] exp_pd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic r, logic v, logic w, amo_op_e op, logic [31:0] ad,
                                  logic [63:0] dat, logic [7:0] st, logic er, logic epv, logic [63:0] epd);
    vec_t x;
    x.rst = r; x.valid = v; x.write = w; x.amo = op; x.addr = ad; x.data = dat; x.strb = st;
    x.exp_ready = er; x.exp_pv = epv; x.exp_pd = epd;
    vecs.push_back(x);
  endfunction

  task automatic drive(input logic r, input logic v, input logic w, input amo_op_e op,
                       input logic [31:0] ad, input logic [63:0] dat, input logic [7:0] st);
    rst          = r;
    req          = '0;
    req.q_valid  = v;
    req.q.write  = w;
    req.q.amo    = op;
    req.q.addr   = ad;
    req.q.data   = dat;
    req.q.strb   = st;
    req.q.user   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    amo_op_e op;
    logic [7:0] st;
    for (int i = 0; i < NumWords; i++) ref_mem[i] = '0;
    drive(1, 0, 0, AMONone, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    //      rst v  w  amo      addr      data                   strb   rdy pv data
    add_vec(1, 1, 0, AMONone, 0,        64'h0,                 8'hFF, 0, 0, 64'h0);
    add_vec(1, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 0, 0, 64'h0);
    add_vec(0, 1, 1, AMONone, 5,        64'hDEAD_BEEF_0123_4567, 8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 0, AMONone, 5,        64'h0,                 8'hFF, 1, 1, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 1, 64'hDEAD_BEEF_0123_4567);
    add_vec(0, 1, 1, AMONone, 6,        64'h1234_5678_7FFF_FFFF, 8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 0, AMOAdd,  6,        64'h1,                 8'h0F, 1, 1, 64'h0);
    add_vec(0, 1, 0, AMONone, 6,        64'h0,                 8'hFF, 0, 1, 64'h1234_5678_7FFF_FFFF);
    add_vec(0, 1, 0, AMONone, 6,        64'h0,                 8'hFF, 1, 0, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 1, 64'h1234_5678_8000_0000);
    add_vec(0, 1, 1, AMONone, 7,        64'h0000_0005_FFFF_FFFF, 8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 0, AMOMax,  7,        64'h0,                 8'hFF, 1, 1, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 0, 1, 64'h0000_0005_FFFF_FFFF);
    add_vec(0, 1, 0, AMONone, 7,        64'h0,                 8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 1, AMONone, 7,        64'h0000_0005_FFFF_FFFF, 8'hFF, 1, 1, 64'h0000_0005_0000_0000);
    add_vec(0, 1, 0, AMOMaxu, 7,        64'h0,                 8'hFF, 1, 1, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 0, 1, 64'h0000_0005_FFFF_FFFF);
    add_vec(0, 1, 0, AMONone, 7,        64'h0,                 8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 0, AMOSwap, 8,        64'hCAFE_F00D_1111_2222, 8'hFF, 1, 1, 64'h0000_0005_FFFF_FFFF);
    add_vec(0, 1, 0, AMONone, 8,        64'h0,                 8'hFF, 0, 1, 64'h0);
    add_vec(0, 1, 0, AMONone, 8,        64'h0,                 8'hFF, 1, 0, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 1, 64'hCAFE_F00D_1111_2222);
    add_vec(0, 1, 1, AMONone, 9,        64'h1111,              8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 0, AMOAdd,  9,        64'h5,                 8'hFF, 1, 1, 64'h0);
    add_vec(1, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 0, 0, 64'h0);
    add_vec(0, 1, 0, AMONone, 9,        64'h0,                 8'hFF, 1, 0, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 1, 64'h1111);
    add_vec(0, 1, 0, AMONone, 32'h405,  64'h0,                 8'hFF, 1, 0, 64'h0);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 1, 64'hDEAD_BEEF_0123_4567);
    add_vec(0, 1, 1, AMONone, 1,        64'hA1,                8'hFF, 1, 0, 64'h0);
    add_vec(0, 1, 1, AMONone, 2,        64'hA2,                8'hFF, 1, 1, 64'h0);
    add_vec(0, 1, 1, AMONone, 3,        64'hA3,                8'hFF, 1, 1, 64'h0);
    add_vec(0, 1, 0, AMONone, 1,        64'h0,                 8'hFF, 1, 1, 64'h0);
    add_vec(0, 1, 0, AMONone, 2,        64'h0,                 8'hFF, 1, 1, 64'hA1);
    add_vec(0, 1, 0, AMONone, 3,        64'h0,                 8'hFF, 1, 1, 64'hA2);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 1, 64'hA3);
    add_vec(0, 0, 0, AMONone, 0,        64'h0,                 8'hFF, 1, 0, 64'h0);

    tbl_on = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].write, vecs[i].amo,
            vecs[i].addr, vecs[i].data, vecs[i].strb);
      tbl_ready = vecs[i].exp_ready;
      tbl_pv    = vecs[i].exp_pv;
      tbl_pd    = vecs[i].exp_pd;
      tick();
    end
    tbl_on = 1'b0;

    // Randomized traffic on a small address window (with junk upper
    // address bits) so atomics and reads collide often.
    for (int n = 0; n < 3000; n++) begin
      op = ($urandom_range(0, 1) == 0) ? AMONone : amo_op_e'(4'($urandom_range(0, 11)));
      st = (op != AMONone && $urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), op,
            ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)),
            {$urandom(), $urandom()}, st);
      tick();
    end

    drive(0, 0, 0, AMONone, 0, 0, 0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
